// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types for the accumulator CPU run-control harness.
//   opcode_e      : accumulator CPU opcodes. A load image word is {opcode, operand address}.
//   run_state_e   : run-control FSM states.
//   run_status_t  : final report of a run (done, timeout, final_pc, cycle_count).
// The status struct is sized by RUN_ADDR_W / RUN_CNT_W. To change the widths of
// cpu_run_ctrl, change these localparams rather than overriding the module parameters.
package cpu_run_ctrl_pkg;

  localparam int unsigned RUN_ADDR_W   = 5;
  localparam int unsigned RUN_DATA_W   = 8;
  localparam int unsigned RUN_CNT_W    = 16;
  localparam int unsigned RUN_RST_HOLD = 10;

  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    HOLD  = 3'd3,
    RUN   = 3'd4,
    DONE  = 3'd5
  } run_state_e;

  typedef struct packed {
    logic                  done;
    logic                  timeout;
    logic [RUN_ADDR_W-1:0] final_pc;
    logic [RUN_CNT_W-1:0]  cycle_count;
  } run_status_t;

endpackage

// File: rtl/cpu_run_watchdog.sv
// Run watchdog for the CPU run controller.
// Counts cpu_tick pulses while the run is enabled, compares the count against the
// max_cycles limit latched at start, resolves halt against limit, and captures final_pc.
// Ports:
//   master_clk, rst_ : clock, async active-low reset
//   clr              : accepted start; latches max_cycles and clears done/timeout/count
//   run_en           : FSM is in RUN and no abort this cycle
//   max_cycles       : watchdog limit (0 means time out on the first tick)
//   cpu_tick         : one pulse per CPU clock edge
//   cpu_halt, pc_in  : CPU halt flag and program counter
//   fin              : combinational; the run ends at this edge
//   status           : registered run report
module cpu_run_watchdog
  import cpu_run_ctrl_pkg::*;
(
  input  logic                  master_clk,
  input  logic                  rst_,
  input  logic                  clr,
  input  logic                  run_en,
  input  logic [RUN_CNT_W-1:0]  max_cycles,
  input  logic                  cpu_tick,
  input  logic                  cpu_halt,
  input  logic [RUN_ADDR_W-1:0] pc_in,
  output logic                  fin,
  output run_status_t           status
);

  logic [RUN_CNT_W-1:0] max_q;
  logic [RUN_CNT_W-1:0] cnt_inc;
  logic                 hit;

  // Saturate rather than wrap; the limit is reached before saturation anyway.
  assign cnt_inc = (&status.cycle_count) ? status.cycle_count
                                         : status.cycle_count + RUN_CNT_W'(1);
  // A zero limit trips on the first tick.
  assign hit = (cnt_inc == max_q) || (max_q == '0);
  // Halt needs no tick; it also wins over a limit-reaching tick (timeout stays 0).
  assign fin = run_en && (cpu_halt || (cpu_tick && hit));

  always_ff @(posedge master_clk or negedge rst_) begin
    if (!rst_) begin
      max_q  <= '0;
      status <= '0;
    end else if (clr) begin
      max_q              <= max_cycles;
      status.done        <= 1'b0;
      status.timeout     <= 1'b0;
      status.cycle_count <= '0;
    end else if (run_en) begin
      if (cpu_tick) status.cycle_count <= cnt_inc;
      if (fin) begin
        status.done     <= 1'b1;
        status.timeout  <= !cpu_halt;
        status.final_pc <= pc_in;
      end
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run-control harness for the accumulator CPU.
// Clears program memory, loads an image over a valid/ready stream with the CPU held
// in reset, releases reset after RST_HOLD cycles, then runs until halt or watchdog.
// Ports:
//   master_clk, rst_          : clock, async active-low reset
//   start, abort              : control pulses (abort wins; start only from IDLE/DONE)
//   load_valid/ready/addr/data/last : image load stream
//   max_cycles                : watchdog limit, latched on start
//   cpu_tick, cpu_halt, pc_in : CPU observation
//   cpu_rst_                  : CPU reset, active-low
//   mem_we/addr/wdata         : program memory write port
//   busy, done, timeout, final_pc, cycle_count : run status
// Every output is registered.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W   = RUN_ADDR_W,   // DEPTH = 2**ADDR_W
  parameter int unsigned DATA_W   = RUN_DATA_W,
  parameter int unsigned CNT_W    = RUN_CNT_W,
  parameter int unsigned RST_HOLD = RUN_RST_HOLD
)(
  input  logic              master_clk,
  input  logic              rst_,
  input  logic              start,
  input  logic              abort,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic [CNT_W-1:0]  max_cycles,
  input  logic              cpu_tick,
  input  logic              cpu_halt,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              cpu_rst_,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [ADDR_W-1:0] final_pc,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam int unsigned HOLD_W = (RST_HOLD < 1) ? 1 : $clog2(RST_HOLD + 1);

  run_state_e        st, st_nx;
  logic [HOLD_W-1:0] hold_cnt, hold_nx;
  logic              mem_we_nx, busy_nx, cpu_rst_nx, load_ready_nx;
  logic [ADDR_W-1:0] mem_addr_nx;
  logic [DATA_W-1:0] mem_wdata_nx;
  logic              start_ok, run_en, wd_fin;
  run_status_t       status;

  assign start_ok = start && !abort && ((st == IDLE) || (st == DONE));
  assign run_en   = (st == RUN) && !abort;

  cpu_run_watchdog u_wdog (
    .master_clk (master_clk),
    .rst_       (rst_),
    .clr        (start_ok),
    .run_en     (run_en),
    .max_cycles (max_cycles),
    .cpu_tick   (cpu_tick),
    .cpu_halt   (cpu_halt),
    .pc_in      (pc_in),
    .fin        (wd_fin),
    .status     (status)
  );

  assign done        = status.done;
  assign timeout     = status.timeout;
  assign final_pc    = status.final_pc;
  assign cycle_count = status.cycle_count;

  always_comb begin
    st_nx        = st;
    hold_nx      = hold_cnt;
    mem_we_nx    = 1'b0;
    mem_addr_nx  = mem_addr;
    mem_wdata_nx = mem_wdata;
    case (st)
      IDLE, DONE: begin
        // Address 0 goes out in the first CLEAR cycle.
        if (start_ok) begin
          st_nx        = CLEAR;
          mem_we_nx    = 1'b1;
          mem_addr_nx  = '0;
          mem_wdata_nx = '0;
        end
      end
      CLEAR: begin
        // The top address is on the bus this cycle, so that write completes the sweep.
        if (&mem_addr) begin
          st_nx = LOAD;
        end else begin
          mem_we_nx    = 1'b1;
          mem_addr_nx  = mem_addr + ADDR_W'(1);
          mem_wdata_nx = '0;
        end
      end
      LOAD: begin
        if (load_valid && load_ready) begin
          mem_we_nx    = 1'b1;
          mem_addr_nx  = load_addr;
          mem_wdata_nx = load_data;
          // Enter HOLD together with the final write; the hold count starts there,
          // so RST_HOLD full cycles of reset follow the last write.
          if (load_last) begin
            st_nx   = HOLD;
            hold_nx = '0;
          end
        end
      end
      HOLD: begin
        if (hold_cnt == HOLD_W'(RST_HOLD)) st_nx = RUN;
        else                               hold_nx = hold_cnt + HOLD_W'(1);
      end
      RUN: begin
        if (wd_fin) st_nx = DONE;
      end
      default: st_nx = IDLE;
    endcase
    if (abort) begin
      st_nx     = IDLE;
      mem_we_nx = 1'b0;
      hold_nx   = '0;
    end
    // Remaining outputs are pure functions of the next state, registered below.
    busy_nx       = (st_nx == CLEAR) || (st_nx == LOAD) || (st_nx == HOLD) || (st_nx == RUN);
    cpu_rst_nx    = (st_nx == RUN) || (st_nx == DONE);
    load_ready_nx = (st_nx == LOAD);
  end

  always_ff @(posedge master_clk or negedge rst_) begin
    if (!rst_) begin
      st         <= IDLE;
      hold_cnt   <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      cpu_rst_   <= 1'b0;
      load_ready <= 1'b0;
    end else begin
      st         <= st_nx;
      hold_cnt   <= hold_nx;
      mem_we     <= mem_we_nx;
      mem_addr   <= mem_addr_nx;
      mem_wdata  <= mem_wdata_nx;
      busy       <= busy_nx;
      cpu_rst_   <= cpu_rst_nx;
      load_ready <= load_ready_nx;
    end
  end

endmodule
